// File: rtl/bcd_to_bin_5d.sv
// bcd_to_bin_5d: fixed-latency five-digit packed BCD to 16-bit binary converter with digit/overflow flags
module bcd_to_bin_5d #(
  parameter logic [15:0] ERR_CODE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [19:0] BCD,
  output logic [15:0] Binary,
  output logic        busy,
  output logic        done,
  output logic        err_digit,
  output logic        err_ovf
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t      state;
  logic [19:0] cap;
  logic [16:0] acc, acc_nxt;
  logic [2:0]  cnt;
  logic        bad, in_bad;
  logic [4:0]  sh;
  logic [3:0]  dig;
  // digits are consumed most significant first, so counter 0 selects bits [19:16]
  always_comb begin
    sh = 5'd16 - {cnt, 2'b00};
    dig = 4'(cap >> sh);
    acc_nxt = (acc << 3) + (acc << 1) + {13'd0, dig};
    in_bad = 1'b0;
    for (int i = 0; i < 5; i++) in_bad = in_bad | (BCD[4*i +: 4] > 4'd9);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap       <= '0;
      acc       <= '0;
      cnt       <= '0;
      bad       <= 1'b0;
      Binary    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_digit <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cap   <= BCD;
          bad   <= in_bad;
          acc   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          acc <= acc_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd4) begin
            state     <= DONE;
            done      <= 1'b1;
            Binary    <= (bad || acc_nxt[16]) ? ERR_CODE : acc_nxt[15:0];
            err_digit <= bad;
            err_ovf   <= !bad && acc_nxt[16];
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_bin_5d.sv
// tb_bcd_to_bin_5d: directed checks of latency, results, flags, hold behaviour and reset abort
module tb_bcd_to_bin_5d;
  logic        clk = 0, rst_n = 0, start = 0;
  logic [19:0] bcd = '0;
  logic [15:0] bin;
  logic        busy, done, err_digit, err_ovf;
  int          checks = 0, errors = 0;
  logic [15:0] prev_bin = 0;
  logic        prev_d = 0, prev_o = 0;

  bcd_to_bin_5d dut (
    .clk(clk), .rst_n(rst_n), .start(start), .BCD(bcd), .Binary(bin),
    .busy(busy), .done(done), .err_digit(err_digit), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start a conversion, optionally hold start high and change BCD during CONV
  task automatic conv(input logic [19:0] b, input logic [15:0] eb, input logic ed, input logic eo,
                      input logic hold, input logic [19:0] nb);
    @(negedge clk);
    bcd = b;
    start = 1;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = (i < 6) ? hold : 1'b0;
      bcd = nb;
      chk($sformatf("busy c%0d", i), busy, 1);
      chk($sformatf("done c%0d", i), done, i == 6);
      if (i < 6) begin
        chk($sformatf("hold bin c%0d", i), bin, prev_bin);
        chk($sformatf("hold flags c%0d", i), {err_digit, err_ovf}, {prev_d, prev_o});
      end
    end
    chk($sformatf("bin %h", b), bin, eb);
    chk($sformatf("err_digit %h", b), err_digit, ed);
    chk($sformatf("err_ovf %h", b), err_ovf, eo);
    @(negedge clk);
    chk("idle busy", busy, 0);
    chk("idle done", done, 0);
    chk("idle hold bin", bin, eb);
    prev_bin = eb;
    prev_d = ed;
    prev_o = eo;
  endtask

  initial begin
    logic [3:0]  d [5];
    logic [19:0] rb;
    int          val;
    #12;
    chk("reset bin", bin, 0);
    chk("reset flags", {busy, done, err_digit, err_ovf}, 0);
    rst_n = 1;
    // BCD changes with start low must be ignored
    repeat (2) begin
      @(negedge clk);
      bcd = 20'h54321;
      chk("idle ignore busy", busy, 0);
    end
    conv(20'h00000, 16'h0000, 0, 0, 0, 20'h00000);
    conv(20'h12345, 16'h3039, 0, 0, 0, 20'h12345);
    conv(20'h65535, 16'hFFFF, 0, 0, 0, 20'h65535);
    conv(20'h65536, 16'hFFFF, 0, 1, 0, 20'h65536);
    conv(20'h1A345, 16'hFFFF, 1, 0, 0, 20'h1A345);
    conv(20'hF9999, 16'hFFFF, 1, 0, 0, 20'hF9999);
    conv(20'h00042, 16'h002A, 0, 0, 1, 20'h99999);
    conv(20'h99999, 16'hFFFF, 0, 1, 0, 20'h99999);
    conv(20'h09999, 16'd9999, 0, 0, 0, 20'h00000);
    // reset during CONV cycle 3
    @(negedge clk);
    bcd = 20'h00100;
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset busy", busy, 1);
    rst_n = 0;
    #1;
    chk("async rst bin", bin, 0);
    chk("async rst ctl", {busy, done, err_digit, err_ovf}, 0);
    @(negedge clk);
    rst_n = 1;
    prev_bin = 0;
    prev_d = 0;
    prev_o = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("no done after abort %0d", i), {busy, done}, 0);
    end
    conv(20'h00100, 16'h0064, 0, 0, 0, 20'h00100);
    // random sweep of valid values against a decimal model
    for (int n = 0; n < 20; n++) begin
      val = 0;
      for (int k = 4; k >= 0; k--) begin
        d[k] = 4'($urandom_range(0, 9));
        val = val * 10 + int'(d[k]);
      end
      rb = {d[4], d[3], d[2], d[1], d[0]};
      conv(rb, val > 65535 ? 16'hFFFF : 16'(val), 0, val > 65535, 0, rb);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_to_bin_5d.md
BCD_TO_BIN_5D -- requirements
Module: bcd_to_bin_5d

Interface
REQ-001 Parameter: ERR_CODE, default 16'hFFFF, value driven on Binary when a conversion fails.
REQ-002 Port: clk, input, 1, single system clock; all state updates on the rising edge.
REQ-003 Port: rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 Port: start, input, 1, conversion request, sampled on the rising edge of clk.
REQ-005 Port: BCD, input, 20, five packed BCD digits; digit 4 (most significant) in [19:16], digit 0 in [3:0].
REQ-006 Port: Binary, output, 16, registered unsigned conversion result.
REQ-007 Port: busy, output, 1, high while a conversion is in progress.
REQ-008 Port: done, output, 1, single-cycle pulse marking that the result and flags are valid.
REQ-009 Port: err_digit, output, 1, a captured digit was greater than 9.
REQ-010 Port: err_ovf, output, 1, all digits were valid but the decimal value exceeded 65535.

Function
REQ-011 The state machine SHALL have exactly the states IDLE, CONV and DONE.
REQ-012 IDLE with start=1 SHALL capture BCD into an internal register, clear the 17-bit accumulator and digit counter, and enter CONV.
REQ-013 In IDLE, BCD changes while start=0 SHALL be ignored.
REQ-014 Each CONV cycle SHALL update acc <= acc*10 + digit[cnt], beginning at digit 4 and ending at digit 0, using the captured copy of BCD.
REQ-015 CONV SHALL last exactly 5 cycles, after which the block enters DONE.
REQ-016 The accumulator SHALL be 17 bits wide, so that the value 99999 never wraps.
REQ-017 The digit-invalid status SHALL be computed from the captured BCD at capture time and held until DONE.
REQ-018 Any nibble greater than 9 SHALL NOT shorten the 5-cycle conversion; the latency is fixed.
REQ-019 DONE SHALL last one cycle and then return to IDLE.
REQ-020 On entering DONE, the registered outputs SHALL be set as follows.
 - Digit invalid: Binary=ERR_CODE, err_digit=1, err_ovf=0.
 - Otherwise acc > 65535: Binary=ERR_CODE, err_digit=0, err_ovf=1.
 - Otherwise: Binary=acc[15:0], err_digit=0, err_ovf=0.
REQ-021 err_digit SHALL take priority over err_ovf; the two flags SHALL never be high together.
REQ-022 done SHALL be high only during the DONE cycle.
REQ-023 Latency SHALL be fixed: done is high in the 6th cycle after the edge that sampled start.
REQ-024 busy SHALL be high in CONV and DONE, and low in IDLE.
REQ-025 start SHALL be ignored while busy=1, with no effect on the running conversion and nothing queued.
REQ-026 start=1 in the IDLE cycle that immediately follows DONE SHALL be accepted; back-to-back throughput is one result per 7 cycles.
REQ-027 Binary, err_digit and err_ovf SHALL hold their values from DONE until the next DONE, remaining stable through IDLE and CONV.
REQ-028 An input of all zeros SHALL give Binary=0 with both error flags low.

Reset
REQ-029 While rst_n=0, the block SHALL immediately and asynchronously set: state=IDLE, Binary=16'h0000, busy=0, done=0, err_digit=0, err_ovf=0, accumulator=0, counter=0, captured BCD=0.
REQ-030 Reset asserted mid-conversion SHALL abort the conversion, with no done pulse afterwards.
REQ-031 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-032 BCD=20'h12345, start pulse -> busy for 6 cycles, then done in cycle 6 with Binary=16'h3039 and both flags 0.
REQ-033 BCD=20'h65535 -> Binary=16'hFFFF, err_ovf=0, err_digit=0; then BCD=20'h65536 -> Binary=16'hFFFF, err_ovf=1.
REQ-034 BCD=20'h1A345 -> err_digit=1, err_ovf=0, Binary=16'hFFFF, with done still in cycle 6; BCD=20'hF9999 -> err_digit=1, err_ovf=0.
REQ-035 Start with BCD=20'h00042, then BCD=20'h99999 with start held high during CONV -> a single done with Binary=16'h002A; the next start after done converts 99999 and sets err_ovf=1.
REQ-036 rst_n pulsed low in CONV cycle 3 of BCD=20'h00100 -> all outputs are 0 at once with no done; after release, BCD=20'h00100 gives Binary=16'h0064.
REQ-037 Random sweep of all valid 5-digit values compared against a reference model -> Binary, flags and latency match for every sample.
